// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: arbiter state type and one-hot grant encodings for axis_arb_2to1
package axis_arb_pkg;
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;
    function automatic logic [1:0] grant_of(arb_state_t s);
        return s == LOCK0 ? GRANT_0 : s == LOCK1 ? GRANT_1 : GRANT_NONE;
    endfunction
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: single-stage registered AXI-Stream output with pass-through ready
module axis_reg_slice #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d, last_q, last_d, load;
    always_comb begin
        in_ready = !valid_q || out_ready;
        load     = in_valid && in_ready;
        data_d   = load ? in_data : data_q;
        last_d   = load ? in_last : last_q;
        valid_d  = load || (valid_q && !out_ready);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
endmodule

// File: rtl/axis_arb_2to1.sv
// axis_arb_2to1: packet-locked 2:1 AXI-Stream arbiter; define AXIS_ARB_RR_EN for round-robin ties
import axis_arb_pkg::*;
module axis_arb_2to1 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_0,
    input  logic             valid_0,
    input  logic             last_0,
    output logic             ready_0,
    input  logic [WIDTH-1:0] data_1,
    input  logic             valid_1,
    input  logic             last_1,
    output logic             ready_1,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             last,
    input  logic             ready,
    output logic [1:0]       grant,
    output logic             busy
);
    arb_state_t       state_q, state_d, tie_pick;
    logic [1:0]       grant_q;
    logic             busy_q, sel_valid, sel_last, slice_ready, acc_last;
    logic [WIDTH-1:0] sel_data;
`ifdef AXIS_ARB_RR_EN
    logic last_grant_q, last_grant_d;
    assign tie_pick     = last_grant_q ? LOCK0 : LOCK1;
    assign last_grant_d = acc_last ? state_q == LOCK1 : last_grant_q;
    always_ff @(posedge clk) last_grant_q <= rst ? 1'b1 : last_grant_d;
`else
    assign tie_pick = LOCK0;
`endif
    always_comb begin
        sel_valid = state_q == LOCK0 ? valid_0 : state_q == LOCK1 ? valid_1 : 1'b0;
        sel_data  = state_q == LOCK1 ? data_1 : data_0;
        sel_last  = state_q == LOCK1 ? last_1 : last_0;
        ready_0   = state_q == LOCK0 && slice_ready;
        ready_1   = state_q == LOCK1 && slice_ready;
        acc_last  = sel_valid && slice_ready && sel_last;
        state_d   = state_q;
        if (state_q == IDLE)
            state_d = valid_0 && valid_1 ? tie_pick : valid_0 ? LOCK0 : valid_1 ? LOCK1 : IDLE;
        else if (acc_last)
            state_d = IDLE;
    end
    // grant/busy are registered copies of the next state so they track state_q exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= GRANT_NONE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_of(state_d);
            busy_q  <= state_d != IDLE;
        end
    end
    assign grant = grant_q;
    assign busy  = busy_q;
    axis_reg_slice #(.WIDTH(WIDTH)) u_out (
        .clk(clk), .rst(rst),
        .in_data(sel_data), .in_valid(sel_valid), .in_last(sel_last), .in_ready(slice_ready),
        .out_data(data), .out_valid(valid), .out_last(last), .out_ready(ready)
    );
endmodule

// File: tb/tb_axis_arb_2to1.sv
// tb_axis_arb_2to1: randomized packet sources checked against a rule-level arbiter model
module tb_axis_arb_2to1;
    localparam int W = 16;
    typedef logic [W:0] beat_t;
    logic         clk = 1'b0, rst, ready, valid, last, busy, ready_0, ready_1;
    logic [W-1:0] data;
    logic [1:0]   grant;
    logic [W-1:0] sd [2];
    logic         sv [2], sl [2];
    always #5 clk = ~clk;
    axis_arb_2to1 #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .data_0(sd[0]), .valid_0(sv[0]), .last_0(sl[0]), .ready_0(ready_0),
        .data_1(sd[1]), .valid_1(sv[1]), .last_1(sl[1]), .ready_1(ready_1),
        .data(data), .valid(valid), .last(last), .ready(ready),
        .grant(grant), .busy(busy)
    );
    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    beat_t      src_q [2][$];
    beat_t      exp_q [$];
    int         own_q [$];
    logic [1:0] refill_en = 2'b00;
    bit         gap_en = 0;
    int         fix_len = 0, rdy_pct = 100, lg = 1;
    bit         acc [2] = '{0, 0};
    bit         p_rst = 1, p_v0 = 0, p_v1 = 0, p_valid = 0, p_ready = 0, p_load = 0, p_last_acc = 0;
    logic [1:0] p_grant = 2'b00;
    beat_t      p_in = '0, p_out = '0;
    task automatic gen_pkt(input int n);
        int len;
        len = fix_len != 0 ? fix_len : int'($urandom_range(1, 4));
        for (int i = 0; i < len; i++) src_q[n].push_back({i == len - 1, W'($urandom)});
    endtask
    // Rule-level model: checks this cycle's outputs against what last cycle's inputs imply
    task automatic monitor();
        logic [1:0] exp_g, tie;
        int n;
`ifdef AXIS_ARB_RR_EN
        tie = lg == 1 ? 2'b01 : 2'b10;
`else
        tie = 2'b01;
`endif
        if (p_rst) begin
            check("rst_grant", 32'(grant), 0);
            check("rst_valid", 32'(valid), 0);
            check("rst_beat", 32'({last, data}), 0);
        end else begin
            if (p_grant == 2'b00)
                exp_g = !(p_v0 || p_v1) ? 2'b00 : (p_v0 && p_v1) ? tie : p_v0 ? 2'b01 : 2'b10;
            else
                exp_g = p_last_acc ? 2'b00 : p_grant;
            check("grant", 32'(grant), 32'(exp_g));
            check("valid", 32'(valid), 32'(p_load || (p_valid && !p_ready)));
            if (p_load) check("load_beat", 32'({last, data}), 32'(p_in));
            else if (p_valid && !p_ready) check("hold_beat", 32'({last, data}), 32'(p_out));
        end
        check("busy", 32'(busy), 32'(grant != 2'b00));
        check("ready_0", 32'(ready_0), 32'(grant == 2'b01 && (!valid || ready)));
        check("ready_1", 32'(ready_1), 32'(grant == 2'b10 && (!valid || ready)));
        if (!rst && p_grant == 2'b00 && grant != 2'b00) begin
            n = int'(grant[1]);
            own_q.push_back(n);
            for (int i = 0; i < src_q[n].size(); i++) begin
                exp_q.push_back(src_q[n][i]);
                if (src_q[n][i][W]) break;
            end
        end
        if (!rst && valid && ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 32'({last, data}), 32'hffff_ffff);
            else check("out_beat", 32'({last, data}), 32'(exp_q.pop_front()));
        end
        acc[0] = !rst && sv[0] && ready_0;
        acc[1] = !rst && sv[1] && ready_1;
        if (acc[0] && sl[0]) lg = 0;
        if (acc[1] && sl[1]) lg = 1;
        if (rst) begin
            lg = 1;
            exp_q.delete();
        end
        p_rst = rst; p_grant = grant; p_v0 = sv[0]; p_v1 = sv[1];
        p_valid = valid; p_ready = ready; p_load = acc[0] || acc[1];
        p_in = acc[0] ? {sl[0], sd[0]} : {sl[1], sd[1]};
        p_last_acc = (acc[0] && sl[0]) || (acc[1] && sl[1]);
        p_out = {last, data};
    endtask
    task automatic drive();
        for (int n = 0; n < 2; n++) begin
            bit hold;
            hold = sv[n] && !acc[n];
            if (acc[n]) void'(src_q[n].pop_front());
            if (refill_en[n] && src_q[n].size() == 0) gen_pkt(n);
            sv[n] = src_q[n].size() != 0 && (hold || !gap_en || $urandom_range(0, 3) != 0);
            {sl[n], sd[n]} = sv[n] ? src_q[n][0] : '0;
        end
        ready = int'($urandom_range(0, 99)) < rdy_pct;
    endtask
    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1 drive();
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        src_q[0].delete();
        src_q[1].delete();
        sv = '{0, 0};
        cyc();
        cyc();
        rst = 1'b0;
    endtask
    task automatic wait_acc(input int n, input int cnt, input string tag);
        int seen = 0, t = 0;
        while (seen < cnt && t < 40) begin
            cyc();
            t++;
            if (acc[n]) seen++;
        end
        check(tag, 32'(seen), 32'(cnt));
    endtask
    initial begin
        int cnt;
        rst = 1'b1; ready = 1'b0; sv = '{0, 0}; sl = '{0, 0}; sd = '{0, 0};
        @(posedge clk);
        #1;
        do_reset();
        // three-beat packet on source 0, latency and grant window
        cyc();
        src_q[0].push_back({1'b0, 16'h0011});
        src_q[0].push_back({1'b0, 16'h0022});
        src_q[0].push_back({1'b1, 16'h0033});
        cyc();
        check("t1_c0_grant", 32'(grant), 0);
        check("t1_c0_ready", 32'(ready_0), 0);
        cyc();
        check("t1_c1_grant", 32'(grant), 1);
        check("t1_c1_ready", 32'(ready_0), 1);
        cyc();
        check("t1_c2_beat", 32'({valid, last, data}), 32'h2_0011);
        check("t1_c2_grant", 32'(grant), 1);
        cyc();
        check("t1_c3_beat", 32'({valid, last, data}), 32'h2_0022);
        check("t1_c3_grant", 32'(grant), 1);
        cyc();
        check("t1_c4_beat", 32'({valid, last, data}), 32'h3_0033);
        check("t1_c4_grant", 32'(grant), 0);
        cyc();
        check("t1_c5_valid", 32'(valid), 0);
        // both sources requesting 2-beat packets continuously
        refill_en = 2'b11; fix_len = 2;
        do_reset();
        own_q.delete();
        for (int t = 0; t < 60 && own_q.size() < 4; t++) cyc();
        check("tie_count", 32'(own_q.size() >= 4), 1);
        for (int i = 0; i < 4 && i < own_q.size(); i++)
`ifdef AXIS_ARB_RR_EN
            check("tie_owner", 32'(own_q[i]), 32'(i % 2));
`else
            check("tie_owner", 32'(own_q[i]), 0);
`endif
        // back-to-back single-beat packets: one output beat every other cycle
        refill_en = 2'b01; fix_len = 1;
        do_reset();
        repeat (6) cyc();
        cnt = 0;
        repeat (10) begin
            cyc();
            cnt += int'(valid);
        end
        check("b2b_beats", 32'(cnt), 5);
        // source 1 mid-packet while source 0 requests, then 5-cycle backpressure
        refill_en = 2'b00; fix_len = 0;
        do_reset();
        for (int i = 0; i < 4; i++) src_q[1].push_back({i == 3, W'($urandom)});
        wait_acc(1, 2, "s1_two_beats");
        src_q[0].push_back({1'b1, 16'hA5A5});
        rdy_pct = 0;
        repeat (5) begin
            cyc();
            check("bp_ready_0", 32'(ready_0), 0);
            check("bp_ready_1", 32'(ready_1), 0);
            check("bp_valid", 32'(valid), 1);
        end
        rdy_pct = 100;
        repeat (12) cyc();
        check("bp_drained", 32'(exp_q.size()), 0);
        check("bp_owners", 32'(own_q.size() >= 2 ? own_q[$] : 9), 0);
        // reset in the cycle after beat 2 of a 4-beat packet
        do_reset();
        for (int i = 0; i < 4; i++) src_q[0].push_back({i == 3, W'($urandom)});
        wait_acc(0, 2, "rst_two_beats");
        rst = 1'b1;
        src_q[0].delete();
        sv[0] = 1'b0;
        cyc();
        rst = 1'b0;
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_ready", 32'({ready_0, ready_1}), 0);
        src_q[1].push_back({1'b1, 16'h5A5A});
        repeat (6) cyc();
        check("post_rst_owner", 32'(own_q[$]), 1);
        check("post_rst_drained", 32'(exp_q.size()), 0);
        // randomized traffic with gaps and backpressure
        refill_en = 2'b11; gap_en = 1; rdy_pct = 70;
        do_reset();
        repeat (3000) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
